epp_command_port: RTL and testbench
===================================

Name: epp_command_port

Overview:
- Digilent EPP slave that converts host parallel-port transactions into game-control levels for the tetris core.
- Sits between the board EPP pins and the per-command edge detectors in the top level; each host command becomes a single clean high window on one control line.
- Also exposes a status register (game_over, pending command) and a scratch register for host-side link checks.

Parameters:
HOLD_CYCLES, 50000, clk cycles a command line stays high after a command write (1 ms at 50 MHz); must be >= 4
SYNC_STAGES, 2, flip-flop stages on EppAstb/EppDstb/EppWR before use; must be >= 2

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  synchronous active-low reset
EppAstb  in  1  address strobe, active low, asynchronous to clk
EppDstb  in  1  data strobe, active low, asynchronous to clk
EppWR  in  1  1 = host read, 0 = host write; sampled through the same synchronizer as the strobes
EppWait  out  1  handshake acknowledge to host, active high
EppDB  inout  8  bidirectional data bus; driven only during read acknowledge, otherwise Z
game_over  in  1  status from tetris core
move_left, move_right, move_down, drop, rotate_left, rotate_right  out  1 each  command levels

Behaviour:
- Reset (rst_n=0 at a clk edge): FSM to IDLE; EppWait=0; EppDB=Z; addr_reg=0; scratch=0; all six command outputs=0; hold counter=0. Reset mid-transaction aborts it; the host times out.
- Sync: Astb/Dstb/WR pass through SYNC_STAGES flops with reset value 1. The FSM uses only the synchronized copies.
- FSM states: IDLE, ADDR_WR, ADDR_RD, DATA_WR, DATA_RD, RELEASE.
- IDLE: synced Astb=0 -> ADDR_WR if WR=0, else ADDR_RD. Synced Dstb=0 -> DATA_WR or DATA_RD. If both strobes are low, Astb wins.
- ADDR_WR (one cycle): latch EppDB into addr_reg; go to RELEASE.
- DATA_WR (one cycle): write the register at addr_reg; go to RELEASE.
- ADDR_RD / DATA_RD: drive EppDB with addr_reg or the selected register. Go to RELEASE on the next cycle and keep driving through RELEASE until the strobe returns high.
- RELEASE: EppWait=1 and held. When the active strobe is synced high: EppWait=0, bus to Z, back to IDLE the same cycle.
- EppWait rises exactly 1 clk after entering an action state. Write data is sampled in the cycle the FSM leaves IDLE; the host holds the bus for the whole strobe-low time.
- Register map (addr_reg[1:0]; bits [7:2] ignored):
  - 0 CMD, write-only; reads 0.
  - 1 STATUS, read-only: bit0=game_over, bit1=hold active, others 0.
  - 2 SCRATCH, R/W.
  - 3 reserved: reads 0, writes ignored.
- CMD write with data d:
  - d[0..5] map to move_left, move_right, move_down, drop, rotate_left, rotate_right.
  - Outputs load d[5:0] on the cycle after DATA_WR.
  - Hold counter loads HOLD_CYCLES-1 and counts down once per clk.
  - When the counter reaches 0, all six outputs clear on the next edge, so the high window is exactly HOLD_CYCLES cycles.
  - A CMD write while a hold is active first forces all outputs to 0 for one cycle, then loads the new value with a fresh count. Downstream edge detectors therefore always see a rising edge.
  - d=0 clears immediately with no hold.
  - d[7:6] ignored.
- Counter width: $clog2(HOLD_CYCLES) bits. It must not wrap; it saturates at 0.

Decomposition:
- Shared package epp_pkg: register address constants (CMD=0, STATUS=1, SCRATCH=2), CMD bit indices, FSM state enum.
- One sub-module epp_cmd_hold: the six-bit output register plus hold counter, including the one-cycle re-arm gap.
- The strobe synchronizer reuses the existing generic Synchronizer with BIT_NUM=3 and DEFAULT_VAL=3'b111.

Test Plan:
- Address write 0x02, data write 0xA5, address write 0x02, data read -> EppDB reads 0xA5; EppWait rises 1 clk after the synced strobe low and falls 1 clk after the synced strobe high.
- Data write 0x01 to CMD (HOLD_CYCLES=8) -> move_left high for exactly 8 clks, the other five lines stay 0, STATUS bit1=1 during the hold.
- Write CMD 0x20, then 0x20 again after 3 clks -> rotate_right goes 1, 0 for one cycle, 1 for a further 8 clks.
- game_over=1, read STATUS -> 0x01 when idle; 0x03 when read during a hold.
- Both strobes low together with WR=0 and bus 0x01 -> treated as an address write: addr_reg=0x01, no CMD outputs change.
- rst_n=0 while in RELEASE with EppWait=1 -> next clk EppWait=0, EppDB=Z, outputs 0, SCRATCH=0.

Source files
------------

// File: rtl/epp_pkg.sv
// Shared definitions for the EPP command port: register map, command bit
// positions and the bus FSM state encoding.
package epp_pkg;

   localparam logic [1:0] REG_CMD     = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_SCRATCH = 2'd2;

   localparam int CMD_BITS         = 6;
   localparam int CMD_MOVE_LEFT    = 0;
   localparam int CMD_MOVE_RIGHT   = 1;
   localparam int CMD_MOVE_DOWN    = 2;
   localparam int CMD_DROP         = 3;
   localparam int CMD_ROTATE_LEFT  = 4;
   localparam int CMD_ROTATE_RIGHT = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR_WR,
      ST_ADDR_RD,
      ST_DATA_WR,
      ST_DATA_RD,
      ST_RELEASE
   } epp_state_e;

endpackage

// File: rtl/epp_command_port_if.sv
// EPP strobe/handshake group. The data bus stays a plain inout port on the
// slave so the tristate driver lives at a module boundary.
interface epp_command_port_if;
   logic EppAstb;
   logic EppDstb;
   logic EppWR;
   logic EppWait;

   modport master (output EppAstb, output EppDstb, output EppWR, input EppWait);
   modport slave  (input EppAstb, input EppDstb, input EppWR, output EppWait);
endinterface

// File: rtl/Synchronizer.sv
// Generic multi-bit flop-chain synchronizer with a configurable reset value.
module Synchronizer #(
   parameter int                 BIT_NUM     = 1,
   parameter logic [BIT_NUM-1:0] DEFAULT_VAL = '0,
   parameter int                 STAGES      = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [BIT_NUM-1:0] d_i,
   output logic [BIT_NUM-1:0] q_o
);

   logic [BIT_NUM-1:0] stage_q [STAGES];

   // Shift the asynchronous inputs through the flop chain.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) stage_q[i] <= DEFAULT_VAL;
      end else begin
         stage_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/epp_cmd_hold.sv
// Command level register: holds a written command for HOLD_CYCLES clocks.
// A write that lands while a hold is active inserts one all-zero cycle so
// every downstream edge detector sees a fresh rising edge.
module epp_cmd_hold
   import epp_pkg::*;
#(
   parameter int HOLD_CYCLES = 50000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_i,
   input  logic [CMD_BITS-1:0] data_i,
   output logic [CMD_BITS-1:0] cmd_o,
   output logic                active_o
);

   localparam int              CW       = $clog2(HOLD_CYCLES);
   localparam logic [CW-1:0]   CNT_LOAD = CW'(HOLD_CYCLES - 1);

   logic [CMD_BITS-1:0] cmd_q, cmd_d;
   logic [CMD_BITS-1:0] pend_data_q, pend_data_d;
   logic                pend_q, pend_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                busy;

   assign busy     = (cmd_q != '0) || pend_q;
   assign active_o = busy;
   assign cmd_o    = cmd_q;

   // Next-state for outputs, re-arm gap and saturating down-counter.
   always_comb begin
      cmd_d       = cmd_q;
      cnt_d       = cnt_q;
      pend_d      = pend_q;
      pend_data_d = pend_data_q;
      if (wr_i) begin
         if (data_i == '0) begin
            cmd_d  = '0;
            cnt_d  = '0;
            pend_d = 1'b0;
         end else if (busy) begin
            cmd_d       = '0;
            cnt_d       = '0;
            pend_d      = 1'b1;
            pend_data_d = data_i;
         end else begin
            cmd_d = data_i;
            cnt_d = CNT_LOAD;
         end
      end else if (pend_q) begin
         cmd_d  = pend_data_q;
         cnt_d  = CNT_LOAD;
         pend_d = 1'b0;
      end else if (cmd_q != '0) begin
         if (cnt_q == '0) cmd_d = '0;
         else             cnt_d = cnt_q - CW'(1);
      end
   end

   // Register the command levels and hold counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cmd_q       <= '0;
         cnt_q       <= '0;
         pend_q      <= 1'b0;
         pend_data_q <= '0;
      end else begin
         cmd_q       <= cmd_d;
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
         pend_data_q <= pend_data_d;
      end
   end

endmodule

// File: rtl/epp_command_port.sv
// Digilent EPP slave turning host transactions into tetris control levels,
// plus a status and a scratch register for the host.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for a synchronized strobe (address strobe has priority)
// ST_ADDR_WR | latch bus into the address register
// ST_ADDR_RD | drive the address register onto the bus
// ST_DATA_WR | write the addressed register (CMD fires the hold block)
// ST_DATA_RD | drive the addressed register onto the bus
// ST_RELEASE | EppWait high until the active strobe returns high
module epp_command_port
   import epp_pkg::*;
#(
   parameter int HOLD_CYCLES = 50000,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   epp_command_port_if.slave  epp,
   inout  wire  [7:0]         EppDB,
   input  logic               game_over,
   output logic               move_left,
   output logic               move_right,
   output logic               move_down,
   output logic               drop,
   output logic               rotate_left,
   output logic               rotate_right
);

   logic [2:0]          strb_s;
   logic                astb_s, dstb_s, wr_s;
   epp_state_e          state_q, state_d;
   logic [7:0]          addr_q, addr_d;
   logic [7:0]          scratch_q, scratch_d;
   logic                is_addr_q, is_addr_d;
   logic                rd_q, rd_d;
   logic                cmd_wr;
   logic [CMD_BITS-1:0] cmd;
   logic                hold_active;
   logic                drive_bus;
   logic [7:0]          rdata;

   Synchronizer #(
      .BIT_NUM     (3),
      .DEFAULT_VAL (3'b111),
      .STAGES      (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   ({epp.EppAstb, epp.EppDstb, epp.EppWR}),
      .q_o   (strb_s)
   );

   assign astb_s = strb_s[2];
   assign dstb_s = strb_s[1];
   assign wr_s   = strb_s[0];

   // Next-state decode and register writes for the EPP bus FSM.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      scratch_d = scratch_q;
      is_addr_d = is_addr_q;
      rd_d      = rd_q;
      cmd_wr    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!astb_s) begin
               is_addr_d = 1'b1;
               rd_d      = wr_s;
               state_d   = wr_s ? ST_ADDR_RD : ST_ADDR_WR;
            end else if (!dstb_s) begin
               is_addr_d = 1'b0;
               rd_d      = wr_s;
               state_d   = wr_s ? ST_DATA_RD : ST_DATA_WR;
            end
         end
         ST_ADDR_WR: begin
            addr_d  = EppDB;
            state_d = ST_RELEASE;
         end
         ST_DATA_WR: begin
            if (addr_q[1:0] == REG_SCRATCH) scratch_d = EppDB;
            cmd_wr  = (addr_q[1:0] == REG_CMD);
            state_d = ST_RELEASE;
         end
         ST_ADDR_RD, ST_DATA_RD: begin
            state_d = ST_RELEASE;
         end
         ST_RELEASE: begin
            if (is_addr_q ? astb_s : dstb_s) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state and host-visible registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         scratch_q <= '0;
         is_addr_q <= 1'b0;
         rd_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         scratch_q <= scratch_d;
         is_addr_q <= is_addr_d;
         rd_q      <= rd_d;
      end
   end

   // Read mux: address register on address cycles, else the addressed register.
   always_comb begin
      rdata = 8'h00;
      if (is_addr_q) begin
         rdata = addr_q;
      end else begin
         case (addr_q[1:0])
            REG_STATUS:  rdata = {6'b0, hold_active, game_over};
            REG_SCRATCH: rdata = scratch_q;
            default:     rdata = 8'h00;
         endcase
      end
   end

   assign drive_bus   = (state_q == ST_ADDR_RD) || (state_q == ST_DATA_RD) ||
                        ((state_q == ST_RELEASE) && rd_q);
   assign EppDB       = drive_bus ? rdata : 8'bz;
   assign epp.EppWait = (state_q == ST_RELEASE);

   epp_cmd_hold #(
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_hold (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_i     (cmd_wr),
      .data_i   (EppDB[CMD_BITS-1:0]),
      .cmd_o    (cmd),
      .active_o (hold_active)
   );

   assign move_left    = cmd[CMD_MOVE_LEFT];
   assign move_right   = cmd[CMD_MOVE_RIGHT];
   assign move_down    = cmd[CMD_MOVE_DOWN];
   assign drop         = cmd[CMD_DROP];
   assign rotate_left  = cmd[CMD_ROTATE_LEFT];
   assign rotate_right = cmd[CMD_ROTATE_RIGHT];

endmodule

// File: tb/tb_epp_command_port.sv
// Bench for epp_command_port: a host model drives EPP transactions and a
// timeline model predicts command levels for every clock cycle.
module tb_epp_command_port;

   localparam int HOLD = 16;
   localparam int SYNC = 2;
   localparam int MAXC = 8192;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       game_over = 1'b0;
   logic       host_oe = 1'b0;
   logic [7:0] host_dout = 8'h00;
   wire  [7:0] epp_db;
   logic       ml, mr, md, dr, rl, rr;

   epp_command_port_if epp_if ();

   assign epp_db = host_oe ? host_dout : 8'bz;

   epp_command_port #(
      .HOLD_CYCLES (HOLD),
      .SYNC_STAGES (SYNC)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .epp          (epp_if),
      .EppDB        (epp_db),
      .game_over    (game_over),
      .move_left    (ml),
      .move_right   (mr),
      .move_down    (md),
      .drop         (dr),
      .rotate_left  (rl),
      .rotate_right (rr)
   );

   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         checks = 0;
   int         errors = 0;
   logic [5:0] exp_cmd [MAXC];
   bit         exp_gap [MAXC];
   logic [7:0] m_addr = 8'h00;
   logic [7:0] m_scratch = 8'h00;
   bit         chk_en = 1'b0;
   int         ml_run = 0;
   int         ml_last = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic bit active_at(input int c);
      return (exp_cmd[c] != 6'd0) || exp_gap[c];
   endfunction

   // Command written so that it reaches the outputs at cycle L.
   task automatic model_cmd(input int L, input logic [5:0] d);
      bit busy;
      int s;
      busy = active_at(L - 1);
      for (int c = L; c < MAXC; c++) begin
         exp_cmd[c] = 6'd0;
         exp_gap[c] = 1'b0;
      end
      if (d != 6'd0) begin
         s = busy ? L + 1 : L;
         if (busy) exp_gap[L] = 1'b1;
         for (int c = s; c < s + HOLD && c < MAXC; c++) exp_cmd[c] = d;
      end
   endtask

   function automatic logic [7:0] exp_data(input int c);
      case (m_addr[1:0])
         2'd1:    return {6'b0, active_at(c), game_over};
         2'd2:    return m_scratch;
         default: return 8'h00;
      endcase
   endfunction

   task automatic tick();
      @(negedge clk);
      if (cyc >= MAXC - 1) begin
         errors++;
         $display("FAIL cycle_budget: observed %0d cycles, limit %0d", cyc, MAXC - 1);
         $display("Simulation finished: %0d checks, %0d errors", checks, errors);
         $fatal(1, "cycle budget exhausted");
      end
      if (chk_en) begin
         check("cmd_levels", {26'b0, rr, rl, dr, md, mr, ml}, {26'b0, exp_cmd[cyc]});
         if (ml) ml_run++;
         else begin
            if (ml_run > 0) ml_last = ml_run;
            ml_run = 0;
         end
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic xfer_start(input bit use_a, input bit use_d, input bit rd,
                             input logic [7:0] wd, output logic [7:0] rdata);
      int k;
      int n;
      epp_if.EppWR = rd;
      host_dout    = wd;
      host_oe      = !rd;
      if (use_a) epp_if.EppAstb = 1'b0;
      if (use_d) epp_if.EppDstb = 1'b0;
      k = cyc;
      if (!rd) begin
         if (use_a)                    m_addr = wd;
         else if (m_addr[1:0] == 2'd0) model_cmd(k + SYNC + 2, wd[5:0]);
         else if (m_addr[1:0] == 2'd2) m_scratch = wd;
      end
      n = 0;
      while (epp_if.EppWait !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("wait_rise_cycle", cyc, k + SYNC + 2);
      rdata = epp_db;
   endtask

   task automatic xfer_end();
      int j;
      int n;
      epp_if.EppAstb = 1'b1;
      epp_if.EppDstb = 1'b1;
      host_oe        = 1'b0;
      j = cyc;
      n = 0;
      while (epp_if.EppWait !== 1'b0 && n < 20) begin
         tick();
         n++;
      end
      check("wait_fall_cycle", cyc, j + SYNC + 1);
   endtask

   task automatic wr_addr(input logic [7:0] a);
      logic [7:0] r;
      xfer_start(1'b1, 1'b0, 1'b0, a, r);
      xfer_end();
   endtask

   task automatic wr_data(input logic [7:0] d);
      logic [7:0] r;
      xfer_start(1'b0, 1'b1, 1'b0, d, r);
      xfer_end();
   endtask

   task automatic rd_addr(input string tag, output logic [7:0] r);
      xfer_start(1'b1, 1'b0, 1'b1, 8'h00, r);
      check(tag, r, m_addr);
      xfer_end();
   endtask

   task automatic rd_data(input string tag, output logic [7:0] r);
      xfer_start(1'b0, 1'b1, 1'b1, 8'h00, r);
      check(tag, r, exp_data(cyc));
      xfer_end();
   endtask

   initial begin
      logic [7:0] r;
      int         op;
      logic [7:0] v;

      for (int c = 0; c < MAXC; c++) begin
         exp_cmd[c] = 6'd0;
         exp_gap[c] = 1'b0;
      end
      epp_if.EppAstb = 1'b1;
      epp_if.EppDstb = 1'b1;
      epp_if.EppWR   = 1'b1;
      rst_n = 1'b0;
      ticks(3);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      check("reset_wait", {31'b0, epp_if.EppWait}, 32'd0);
      tick();

      // Reset contents.
      rd_addr("reset_addr", r);
      wr_addr(8'h02);
      rd_data("reset_scratch", r);

      // Scratch round trip.
      wr_addr(8'h02);
      wr_data(8'hA5);
      wr_addr(8'h02);
      rd_data("scratch_a5", r);
      check("scratch_a5_const", r, 8'hA5);

      // Single move_left window.
      wr_addr(8'h00);
      wr_data(8'h01);
      ticks(2 * HOLD);
      check("move_left_width", ml_last, HOLD);

      // Back-to-back rotate_right: one-cycle gap then a fresh window.
      wr_data(8'h20);
      wr_data(8'h20);
      ticks(2 * HOLD);

      // Status idle and during a hold.
      game_over = 1'b1;
      wr_addr(8'h01);
      rd_data("status_idle", r);
      check("status_idle_const", r, 8'h01);
      wr_addr(8'h00);
      wr_data(8'h08);
      wr_addr(8'h01);
      rd_data("status_hold", r);
      check("status_hold_const", r, 8'h03);
      ticks(HOLD + 4);

      // Both strobes low with a write: address write wins.
      wr_addr(8'h00);
      xfer_start(1'b1, 1'b1, 1'b0, 8'h01, r);
      xfer_end();
      rd_addr("both_strobes_addr", r);
      check("both_strobes_const", r, 8'h01);
      ticks(HOLD);

      // Randomized traffic against the model.
      for (int i = 0; i < 60; i++) begin
         op = $urandom_range(0, 5);
         case (op)
            0: begin
               v = 8'($urandom);
               v[1:0] = ($urandom_range(0, 1) == 1) ? 2'd0 : v[1:0];
               wr_addr(v);
            end
            1: begin
               v = 8'($urandom);
               if ($urandom_range(0, 3) == 0) v[5:0] = 6'd0;
               wr_data(v);
            end
            2: rd_data("rand_data_rd", r);
            3: rd_addr("rand_addr_rd", r);
            4: ticks($urandom_range(0, HOLD));
            default: game_over = ~game_over;
         endcase
      end
      ticks(HOLD + 2);

      // Reset while EppWait is high during a CMD write.
      wr_addr(8'h02);
      wr_data(8'h5A);
      wr_addr(8'h00);
      xfer_start(1'b0, 1'b1, 1'b0, 8'h04, r);
      rst_n = 1'b0;
      for (int c = cyc + 1; c < MAXC; c++) begin
         exp_cmd[c] = 6'd0;
         exp_gap[c] = 1'b0;
      end
      m_addr    = 8'h00;
      m_scratch = 8'h00;
      tick();
      check("rst_release_wait", {31'b0, epp_if.EppWait}, 32'd0);
      epp_if.EppAstb = 1'b1;
      epp_if.EppDstb = 1'b1;
      host_oe        = 1'b0;
      tick();
      rst_n = 1'b1;
      ticks(2);
      rd_addr("rst_addr", r);
      wr_addr(8'h02);
      rd_data("rst_scratch", r);
      check("rst_scratch_const", r, 8'h00);
      ticks(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
